// File: rtl/div_scheduler_if.sv
// Handshake bundle between the ID-stage decode and the divide scheduler.
// The master drives the decode requests; the slave (scheduler) drives the control outputs.
interface div_scheduler_if;
    logic       div_issue;
    logic       mfhilo_req;
    logic       divisor_zero;
    logic       abort;
    logic       stall;
    logic       div_load;
    logic       div_step;
    logic       hilo_we;
    logic       dz_err;
    logic       busy;
    logic [5:0] step_cnt;

    modport master (
        output div_issue, mfhilo_req, divisor_zero, abort,
        input  stall, div_load, div_step, hilo_we, dz_err, busy, step_cnt
    );

    modport slave (
        input  div_issue, mfhilo_req, divisor_zero, abort,
        output stall, div_load, div_step, hilo_we, dz_err, busy, step_cnt
    );
endinterface

// File: rtl/div_scheduler.sv
// Sequences an iterative divider: operand load, DIV_CYCLES step cycles, HI/LO write-back,
// and stalls ID while a divide or a dependent MFHI/MFLO is outstanding.
module div_scheduler #(
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic            clk,
    input  logic            rst,
    div_scheduler_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        WRITE = 2'd3
    } state_t;

    localparam logic [5:0] CNT_INIT = DIV_CYCLES[5:0];

    state_t     state_r;
    state_t     state_next_s;
    logic [5:0] cnt_r;
    logic [5:0] cnt_next_s;
    logic       dz_r;
    logic       dz_next_s;
    logic       load_r;
    logic       step_r;
    logic       we_r;
    logic       busy_r;

    // Next-state and counter decode
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        dz_next_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.div_issue && !bus.abort) begin
                    if (bus.divisor_zero) begin
                        dz_next_s = 1'b1;
                    end else begin
                        state_next_s = LOAD;
                        cnt_next_s   = CNT_INIT;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            LOAD: begin
                if (bus.abort) begin
                    state_next_s = IDLE;
                    cnt_next_s   = 6'd0;
                end else begin
                    state_next_s = RUN;
                end
            end
            RUN: begin
                // Compare with <= so a corrupted counter can never wrap below zero
                if (bus.abort) begin
                    state_next_s = IDLE;
                    cnt_next_s   = 6'd0;
                end else if (cnt_r <= 6'd1) begin
                    state_next_s = WRITE;
                    cnt_next_s   = 6'd0;
                end else begin
                    cnt_next_s   = cnt_r - 6'd1;
                end
            end
            WRITE: begin
                state_next_s = IDLE;
                cnt_next_s   = 6'd0;
            end
            default: begin
                state_next_s = IDLE;
                cnt_next_s   = 6'd0;
            end
        endcase
    end

    // State, counter and registered control outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            cnt_r   <= 6'd0;
            dz_r    <= 1'b0;
            load_r  <= 1'b0;
            step_r  <= 1'b0;
            we_r    <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            dz_r    <= dz_next_s;
            load_r  <= (state_next_s == LOAD);
            step_r  <= (state_next_s == RUN);
            we_r    <= (state_next_s == WRITE);
            busy_r  <= (state_next_s != IDLE);
        end
    end

    assign bus.stall    = (bus.div_issue | bus.mfhilo_req) & busy_r;
    assign bus.div_load = load_r;
    assign bus.div_step = step_r;
    assign bus.hilo_we  = we_r;
    assign bus.dz_err   = dz_r;
    assign bus.busy     = busy_r;
    assign bus.step_cnt = cnt_r;

endmodule

// File: tb/tb_div_scheduler.sv
// Self-checking bench for div_scheduler: a table of single-cycle vectors, hand-written
// latency/abort/reset sequences, and random traffic against a timeline-based model.
module tb_div_scheduler;

    localparam int D = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    div_scheduler_if bus ();

    div_scheduler #(.DIV_CYCLES(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        i;
        logic        m;
        logic        z;
        logic        a;
        logic        st;
        logic [10:0] out;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Model: cycle in which the live divide shows div_load (-1 = none), and pending dz_err cycle
    int ld    = -1;
    int dz_at = -1;
    int cyc   = 0;

    int   f_load, l_load, f_step, l_step, l_we, n_we, f_stall, l_stall, l_fall;
    logic prev_busy;

    function automatic logic [10:0] outv();
        return {bus.div_load, bus.div_step, bus.hilo_we, bus.dz_err, bus.busy, bus.step_cnt};
    endfunction

    function automatic logic [10:0] pk(input logic l, s, w, e, b, input int c);
        logic [5:0] c6;
        c6 = c[5:0];
        return {l, s, w, e, b, c6};
    endfunction

    function automatic vec_t mk(input logic i, m, z, a, st, input logic [10:0] out);
        vec_t v;
        v.i = i; v.m = m; v.z = z; v.a = a; v.st = st; v.out = out;
        return v;
    endfunction

    function automatic logic model_active();
        return (ld >= 0) && (cyc >= ld) && (cyc <= ld + D + 1);
    endfunction

    // Expected {stall, outputs} for the current cycle, derived from the op's timeline
    function automatic logic [11:0] model_exp(input logic i, m);
        logic act, l, s, w, e;
        int   c;
        act = model_active();
        l   = act && (cyc == ld);
        s   = act && (cyc >= ld + 1) && (cyc <= ld + D);
        w   = act && (cyc == ld + D + 1);
        e   = (cyc == dz_at);
        c   = l ? D : (s ? D - (cyc - ld - 1) : 0);
        return {(i | m) & act, pk(l, s, w, e, act, c)};
    endfunction

    task automatic model_edge(input logic i, z, a);
        if (model_active()) begin
            if (a && cyc <= ld + D) ld = -1;
        end else if (i && !a) begin
            if (z) dz_at = cyc + 1;
            else   ld    = cyc + 1;
        end
    endtask

    task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic clear_marks();
        f_load = -1; l_load = -1; f_step = -1; l_step = -1; l_we = -1; n_we = 0;
        f_stall = -1; l_stall = -1; l_fall = -1; prev_busy = 1'b0;
    endtask

    task automatic set_in(input logic i, m, z, a);
        bus.div_issue = i; bus.mfhilo_req = m; bus.divisor_zero = z; bus.abort = a;
    endtask

    task automatic do_reset();
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        ld = -1; dz_at = -1; cyc = 0;
        clear_marks();
    endtask

    // One cycle: drive after negedge, check, record events, clock the model at posedge
    task automatic do_cycle(input logic i, m, z, a);
        set_in(i, m, z, a);
        #1;
        check("cycle", {bus.stall, outv()}, model_exp(i, m));
        if (bus.div_load) begin if (f_load < 0) f_load = cyc; l_load = cyc; end
        if (bus.div_step) begin if (f_step < 0) f_step = cyc; l_step = cyc; end
        if (bus.hilo_we)  begin l_we = cyc; n_we++; end
        if (bus.stall)    begin if (f_stall < 0) f_stall = cyc; l_stall = cyc; end
        if (!bus.busy && prev_busy) l_fall = cyc;
        prev_busy = bus.busy;
        @(posedge clk);
        model_edge(i, z, a);
        @(negedge clk);
        cyc++;
    endtask

    vec_t tbl[13];

    initial begin
        tbl[0]  = mk(0, 0, 0, 0, 0, pk(0, 0, 0, 0, 0, 0));
        tbl[1]  = mk(0, 1, 0, 0, 0, pk(0, 0, 0, 0, 0, 0));
        tbl[2]  = mk(1, 0, 1, 0, 0, pk(0, 0, 0, 1, 0, 0));
        tbl[3]  = mk(1, 0, 1, 1, 0, pk(0, 0, 0, 0, 0, 0));
        tbl[4]  = mk(1, 0, 0, 1, 0, pk(0, 0, 0, 0, 0, 0));
        tbl[5]  = mk(1, 0, 0, 0, 0, pk(1, 0, 0, 0, 1, D));
        tbl[6]  = mk(0, 1, 0, 0, 1, pk(0, 1, 0, 0, 1, D));
        tbl[7]  = mk(0, 0, 0, 0, 0, pk(0, 1, 0, 0, 1, D - 1));
        tbl[8]  = mk(0, 0, 0, 1, 0, pk(0, 0, 0, 0, 0, 0));
        tbl[9]  = mk(1, 0, 1, 0, 0, pk(0, 0, 0, 1, 0, 0));
        tbl[10] = mk(1, 0, 0, 0, 0, pk(1, 0, 0, 0, 1, D));
        tbl[11] = mk(1, 0, 0, 1, 1, pk(0, 0, 0, 0, 0, 0));
        tbl[12] = mk(0, 0, 0, 0, 0, pk(0, 0, 0, 0, 0, 0));

        // Reset state while rst is held low
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        check("reset_state", {bus.stall, outv()}, 12'd0);

        // Single-cycle vector table
        do_reset();
        for (int k = 0; k < 13; k++) begin
            set_in(tbl[k].i, tbl[k].m, tbl[k].z, tbl[k].a);
            #1;
            check($sformatf("tbl%0d_stall", k), {11'd0, bus.stall}, {11'd0, tbl[k].st});
            @(posedge clk);
            @(negedge clk);
            check($sformatf("tbl%0d_out", k), {1'b0, outv()}, {1'b0, tbl[k].out});
        end

        // Single divide with MFHI waiting from cycle 2
        do_reset();
        do_cycle(1, 0, 0, 0);
        do_cycle(0, 0, 0, 0);
        for (int c = 2; c <= 37; c++) do_cycle(0, c <= 36, 0, 0);
        check_int("single_load", f_load, 1);
        check_int("single_step_first", f_step, 2);
        check_int("single_step_last", l_step, D + 1);
        check_int("single_we", l_we, D + 2);
        check_int("single_busy_fall", l_fall, D + 3);
        check_int("mfhi_stall_first", f_stall, 2);
        check_int("mfhi_stall_last", l_stall, D + 2);

        // Back-to-back divide held from cycle 1
        do_reset();
        do_cycle(1, 0, 0, 0);
        for (int c = 1; c <= 35; c++) do_cycle(1, 0, 0, 0);
        for (int c = 36; c <= 75; c++) do_cycle(0, 0, 0, 0);
        check_int("b2b_load2", l_load, 36);
        check_int("b2b_we2", l_we, 69);
        check_int("b2b_we_count", n_we, 2);
        check_int("b2b_stall_first", f_stall, 1);

        // Abort in RUN
        do_reset();
        do_cycle(1, 0, 0, 0);
        for (int c = 1; c <= 9; c++) do_cycle(0, 0, 0, 0);
        do_cycle(0, 0, 0, 1);
        for (int c = 11; c <= 45; c++) do_cycle(0, 0, 0, 0);
        check_int("abort_run_fall", l_fall, 11);
        check_int("abort_run_we", n_we, 0);

        // Abort in WRITE is ignored
        do_reset();
        do_cycle(1, 0, 0, 0);
        for (int c = 1; c <= 33; c++) do_cycle(0, 0, 0, 0);
        do_cycle(0, 0, 0, 1);
        for (int c = 35; c <= 37; c++) do_cycle(0, 0, 0, 0);
        check_int("abort_write_we", l_we, D + 2);
        check_int("abort_write_count", n_we, 1);

        // Asynchronous reset mid-RUN
        do_reset();
        do_cycle(1, 0, 0, 0);
        for (int c = 1; c <= 8; c++) do_cycle(0, 0, 0, 0);
        #2;
        rst = 1'b0;
        #1;
        check("async_reset", {bus.stall, outv()}, 12'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        ld = -1; dz_at = -1; cyc = 0;
        clear_marks();
        for (int c = 0; c < 45; c++) do_cycle(0, 0, 0, 0);
        check_int("after_reset_we", n_we, 0);

        // Random traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            do_cycle($urandom_range(3) == 0, $urandom_range(3) == 0,
                     $urandom_range(7) == 0, $urandom_range(49) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_scheduler.md
DIV_SCHEDULER -- requirements
Module: div_scheduler

Interface
REQ-001 The block SHALL be clocked by one clock; reset is asynchronous and active-low.
REQ-002 Parameter: DIV_CYCLES, default 32, number of iterative divider step cycles (legal 1..63).
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: rst  input  1  asynchronous active-low reset.
REQ-005 Port: div_issue  input  1  DIV/DIVU decoded in ID, request to start a divide.
REQ-006 Port: mfhilo_req  input  1  MFHI or MFLO decoded in ID, needs HI/LO valid.
REQ-007 Port: divisor_zero  input  1  ID-stage divisor operand equals zero, valid with div_issue.
REQ-008 Port: abort  input  1  pipeline flush; cancels an in-flight divide.
REQ-009 Port: stall  output  1  hold PC and IF/ID, bubble into ID/EX (combinational).
REQ-010 Port: div_load  output  1  one-cycle pulse, divider latches operands and clears.
REQ-011 Port: div_step  output  1  divider performs one iteration this cycle.
REQ-012 Port: hilo_we  output  1  one-cycle pulse, HI/LO capture divider result.
REQ-013 Port: dz_err  output  1  one-cycle pulse, divide-by-zero detected, HI/LO untouched.
REQ-014 Port: busy  output  1  high in any state other than IDLE.
REQ-015 Port: step_cnt  output  6  remaining step count.

Function
REQ-016 States SHALL be IDLE, LOAD, RUN, WRITE, encoded in registers; all outputs except stall SHALL be registered or decoded from state/counter only.
REQ-017 IDLE: div_issue=1, abort=0, divisor_zero=0 -> LOAD; div_issue=1, divisor_zero=1 -> stay IDLE, dz_err=1 next cycle; else stay IDLE.
REQ-018 LOAD: div_load=1 for exactly one cycle, step_cnt loaded with DIV_CYCLES, next state RUN.
REQ-019 RUN: div_step=1 every cycle; step_cnt decrements by 1 per cycle; when step_cnt==1 next state WRITE (step_cnt becomes 0).
REQ-020 WRITE: hilo_we=1 for exactly one cycle, next state IDLE.
REQ-021 Latency: issue accepted at edge N -> div_load high cycle N+1, div_step high cycles N+2..N+1+DIV_CYCLES, hilo_we high cycle N+2+DIV_CYCLES.
REQ-022 stall SHALL equal (div_issue | mfhilo_req) & busy; no stall in IDLE.
REQ-023 A div_issue arriving while busy SHALL be stalled, not queued; it is accepted on the first IDLE cycle with div_issue still high.
REQ-024 mfhilo_req in WRITE SHALL stall; released in the following IDLE cycle, when HI/LO hold the new result.
REQ-025 abort in LOAD or RUN SHALL force IDLE at the next edge, no hilo_we, step_cnt=0; abort in WRITE SHALL be ignored (result commits); abort with div_issue in IDLE SHALL block acceptance and dz_err.
REQ-026 step_cnt SHALL never wrap below 0; counter width 6 bits, DIV_CYCLES>63 is illegal.
REQ-027 div_load, div_step and hilo_we SHALL be mutually exclusive in every cycle.

Reset
REQ-028 rst low SHALL immediately force IDLE, step_cnt=0, div_load=div_step=hilo_we=dz_err=busy=0, independent of clk.
REQ-029 Reset asserted mid-RUN SHALL discard the operation; no hilo_we after release.
REQ-030 First edge after rst deasserts SHALL behave as IDLE.

Verification
REQ-031 Single divide, DIV_CYCLES=32: div_issue one cycle at edge 0 -> div_load cycle 1, div_step cycles 2..33, hilo_we cycle 34, busy low cycle 35.
REQ-032 MFHI held behind divide: mfhilo_req high from cycle 2 -> stall=1 cycles 2..34, stall=0 cycle 35.
REQ-033 Back-to-back DIV: second div_issue held from cycle 1 -> stalled until cycle 35, accepted, div_load cycle 36, hilo_we cycle 69.
REQ-034 Divide by zero: div_issue=1, divisor_zero=1 in IDLE -> dz_err pulse next cycle, busy stays 0, no div_load/hilo_we.
REQ-035 Abort at cycle 10 (RUN) -> IDLE cycle 11, step_cnt=0, no hilo_we; abort in WRITE cycle -> hilo_we still asserted.
REQ-036 rst low mid-RUN asynchronously -> all outputs 0 before next edge; after release no hilo_we until a new div_issue.
